// File: rtl/maxpool2d_mem.sv
// 2x2 stride-2 max-pool over an HWC int32 tensor in shared memory.
// One request at a time on a single-port controller interface; four reads then one write per output.
module maxpool2d_mem #(
  parameter int CHANNELS = 16,
  parameter int DIM_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  output logic             ready,
  input  logic [31:0]      input_addr,
  input  logic [31:0]      output_addr,
  input  logic [DIM_W-1:0] input_height,
  input  logic [DIM_W-1:0] input_width,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data_out,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [31:0]      mem_data_in,
  input  logic             mem_ready,
  output logic [31:0]      out_count
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [31:0] CH = 32'(CHANNELS);

  state_t             state;
  logic [31:0]        oy, ox, c;
  logic [1:0]         tap;
  logic signed [31:0] run_max;

  logic [31:0]        h32, w32, oh, ow;
  logic [1:0]         tap_next;
  logic signed [31:0] cand;
  logic               last_c, last_ox, last_oy, last_out;
  logic [31:0]        nc, nox, noy;
  logic [31:0]        rd_next_addr, wr_addr, next_out_addr;

  function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [31:0] y,
                                            input logic [31:0] x, input logic [31:0] wd,
                                            input logic [31:0] ch);
    return base + (((y * wd + x) * CH + ch) << 2);
  endfunction

  always_comb begin
    h32      = 32'(input_height);
    w32      = 32'(input_width);
    oh       = h32 >> 1;
    ow       = w32 >> 1;
    tap_next = tap + 2'd1;
    // First tap of a window always loads; later taps win only when strictly greater.
    cand     = (tap == 2'd0 || $signed(mem_data_in) > run_max) ? $signed(mem_data_in) : run_max;
    last_c   = (c == CH - 32'd1);
    last_ox  = (ox == ow - 32'd1);
    last_oy  = (oy == oh - 32'd1);
    last_out = last_c && last_ox && last_oy;
    nc       = last_c ? 32'd0 : c + 32'd1;
    nox      = last_c ? (last_ox ? 32'd0 : ox + 32'd1) : ox;
    noy      = (last_c && last_ox) ? oy + 32'd1 : oy;
    rd_next_addr  = elem_addr(input_addr, (oy << 1) + {31'b0, tap_next[1]},
                              (ox << 1) + {31'b0, tap_next[0]}, w32, c);
    wr_addr       = elem_addr(output_addr, oy, ox, ow, c);
    next_out_addr = elem_addr(input_addr, noy << 1, nox << 1, w32, nc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      done         <= 1'b0;
      ready        <= 1'b1;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_data_out <= 32'd0;
      out_count    <= 32'd0;
      oy           <= 32'd0;
      ox           <= 32'd0;
      c            <= 32'd0;
      tap          <= 2'd0;
      run_max      <= 32'sd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ready     <= 1'b0;
            out_count <= 32'd0;
            if (h32 < 32'd2 || w32 < 32'd2) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              oy       <= 32'd0;
              ox       <= 32'd0;
              c        <= 32'd0;
              tap      <= 2'd0;
              mem_re   <= 1'b1;
              mem_addr <= input_addr;
              state    <= READ;
            end
          end
        end
        READ: begin
          if (mem_ready) begin
            run_max <= cand;
            if (tap == 2'd3) begin
              tap          <= 2'd0;
              mem_re       <= 1'b0;
              mem_we       <= 1'b1;
              mem_addr     <= wr_addr;
              mem_data_out <= cand;
              state        <= WRITE;
            end else begin
              tap      <= tap_next;
              mem_addr <= rd_next_addr;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_we    <= 1'b0;
            out_count <= out_count + 32'd1;
            if (last_out) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              c        <= nc;
              ox       <= nox;
              oy       <= noy;
              mem_re   <= 1'b1;
              mem_addr <= next_out_addr;
              state    <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2d_mem.sv
// Directed bench for maxpool2d_mem (CHANNELS=2) with a word memory model,
// write scoreboard and bus-protocol monitor.
module tb_maxpool2d_mem;
  localparam int          C     = 2;
  localparam logic [31:0] OBASE = 32'd512;

  logic        clk = 1'b0;
  logic        rst, start, done, ready;
  logic [31:0] input_addr, output_addr;
  logic [15:0] input_height, input_width;
  logic [31:0] mem_addr, mem_data_out, mem_data_in, out_count;
  logic        mem_we, mem_re, mem_ready;

  logic signed [31:0] mem [0:255];
  logic [31:0]        snap [0:7];
  logic [63:0]        exp_q [$];

  int   n_checks = 0, n_errors = 0;
  int   viol = 0, bad_reads = 0, req_cycles = 0, bound_w = 3;
  bit   rand_ready = 0, bound_en = 0, stalled = 0;
  logic [31:0] held_addr = 32'd0;

  maxpool2d_mem #(.CHANNELS(C), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .ready(ready),
    .input_addr(input_addr), .output_addr(output_addr),
    .input_height(input_height), .input_width(input_width),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_we(mem_we), .mem_re(mem_re),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .out_count(out_count)
  );

  // clock / memory read path
  always #5 clk = ~clk;
  assign mem_data_in = mem_re ? mem[mem_addr[9:2]] : 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mem_ready is chosen for the upcoming edge, then the current cycle's request is observed.
  always @(negedge clk) begin
    int idx, pix;
    logic [63:0] e;
    mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_re && mem_we) viol++;
    if (stalled && (mem_addr !== held_addr || !(mem_re || mem_we))) viol++;
    stalled   = (mem_re || mem_we) && !mem_ready;
    held_addr = mem_addr;
    if (mem_re || mem_we) req_cycles++;
    if (mem_re && mem_ready && bound_en) begin
      idx = int'(mem_addr >> 2);
      pix = idx / C;
      if (pix / bound_w >= 4 || pix % bound_w >= 2) bad_reads++;
    end
    if (mem_we && mem_ready) begin
      mem[mem_addr[9:2]] = mem_data_out;
      if (exp_q.size() == 0) check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_data_out, e[31:0]);
      end
    end
  end

  task automatic clear_out();
    for (int i = 128; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic push_expected(input int h, input int w);
    int ow;
    logic signed [31:0] m, v;
    ow = w / 2;
    for (int oy = 0; oy < h / 2; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ch = 0; ch < C; ch++) begin
          m = 0;
          for (int t = 0; t < 4; t++) begin
            v = mem[((2 * oy + t / 2) * w + 2 * ox + t % 2) * C + ch];
            if (t == 0 || v > m) m = v;
          end
          exp_q.push_back({OBASE + 32'(((oy * ow + ox) * C + ch) * 4), m});
        end
  endtask

  task automatic load_t1();
    mem[0] = 5;  mem[1] = -3; mem[2] = -3;  mem[3] = 7;
    mem[4] = 9;  mem[5] = -10; mem[6] = 7;  mem[7] = -20;
  endtask

  // exp_done < 0 skips the latency check (stalled runs).
  task automatic run_job(input int h, input int w, input int exp_done, input int exp_cnt);
    int n, done_cyc;
    @(negedge clk);
    input_height = 16'(h);
    input_width  = 16'(w);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    n = 0;
    while (done_cyc < 0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (done) done_cyc = n;
    end
    if (done_cyc < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
      check("out_count", out_count, exp_cnt);
      @(negedge clk);
      check("done_pulse_len", {31'b0, done}, 32'd0);
      check("ready_after", {31'b0, ready}, 32'd1);
    end
    check("sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit saw_done;
    for (int i = 0; i < 256; i++) mem[i] = 0;
    rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
    input_addr = 32'd0; output_addr = OBASE; input_height = 16'd0; input_width = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_re_we", {30'b0, mem_re, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_dout", mem_data_out, 32'd0);
    check("rst_count", out_count, 32'd0);
    rst = 1'b0;

    // 2x2x2: c0 taps {5,-3,9,7}, c1 taps {-3,7,-10,-20}
    load_t1(); clear_out();
    exp_q.push_back({OBASE, 32'd9});
    exp_q.push_back({OBASE + 32'd4, 32'd7});
    run_job(2, 2, 11, 2);
    check("t1_mem0", mem[128], 32'd9);
    check("t1_mem1", mem[129], 32'd7);

    // 4x4x2 ramp with an all-negative window at (oy0,ox1,c1)
    for (int i = 0; i < 32; i++) mem[i] = i;
    mem[5] = -8; mem[7] = -2; mem[13] = -5; mem[15] = -9;
    clear_out(); push_expected(4, 4);
    run_job(4, 4, 41, 8);
    check("t2_neg_window", mem[131], 32'hFFFF_FFFE);
    check("t2_first", mem[128], 32'd10);
    for (int i = 0; i < 8; i++) snap[i] = mem[128 + i];

    // same job with random stalls
    clear_out(); push_expected(4, 4);
    rand_ready = 1;
    run_job(4, 4, -1, 8);
    rand_ready = 0;
    for (int i = 0; i < 8; i++) check("t3_same_mem", mem[128 + i], snap[i]);

    // 5x3x2: odd row/column dropped
    for (int i = 0; i < 30; i++) mem[i] = (i * 37) % 50 - 25;
    clear_out(); push_expected(5, 3);
    bound_en = 1; bound_w = 3; bad_reads = 0;
    run_job(5, 3, 21, 4);
    bound_en = 0;
    check("t4_bad_reads", bad_reads, 32'd0);

    // degenerate
    req_cycles = 0;
    run_job(1, 8, 1, 0);
    check("t5_no_access", req_cycles, 32'd0);

    // reset during third read, then a fresh job
    load_t1(); clear_out();
    @(negedge clk);
    input_height = 16'd2; input_width = 16'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_third_re", {31'b0, mem_re}, 32'd1);
    check("t6_third_addr", mem_addr, 32'd16);
    rst = 1'b1;
    saw_done = 0;
    @(negedge clk);
    check("t6_abort_re", {31'b0, mem_re}, 32'd0);
    check("t6_abort_ready", {31'b0, ready}, 32'd1);
    check("t6_abort_addr", mem_addr, 32'd0);
    repeat (4) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("t6_no_done", {31'b0, saw_done}, 32'd0);
    check("t6_untouched", mem[128], 32'hDEAD_BEEF);
    push_expected(2, 2);
    run_job(2, 2, 11, 2);

    check("protocol_viol", viol, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/maxpool2d_mem.md
# maxpool2d_mem

Downstream stage of the convolution engine: 2×2, stride-2 max-pooling over the conv output tensor held in shared memory. It reads signed 32-bit activations (HWC layout, one word per element), computes the per-channel maximum of each 2×2 window, and writes the pooled tensor back through the same single-port memory controller interface the convolution engine uses. It is started by the softcore after the conv engine reports done, and it reports completion with a one-cycle done pulse.

## Interface
- CHANNELS, 16: channel count C of the input tensor (innermost dimension).
- DIM_W, 16: width of the height/width parameter ports.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only while ready=1.
- done  out  1  one-cycle pulse when the job is complete.
- ready  out  1  high while idle; accepts start.
- input_addr  in  32  byte base address of the input tensor.
- output_addr  in  32  byte base address of the output tensor.
- input_height  in  DIM_W  H.
- input_width  in  DIM_W  W.
- mem_addr  out  32  byte address of the current access.
- mem_data_out  out  32  write data.
- mem_we  out  1  write request.
- mem_re  out  1  read request.
- mem_data_in  in  32  read data; valid in the cycle mem_ready=1 with mem_re=1.
- mem_ready  in  1  controller accepts/completes the current request this cycle.
- out_count  out  32  number of output words written in the current/last job.

## Operation
- Output dims: OH = floor(H/2), OW = floor(W/2); an odd last row/column is dropped.
- Element (y,x,c) is at byte address base + ((y*W + x)*C + c)*4; output uses OW in place of W.
- Output order: oy outer, ox, c inner. Taps per output, in order: (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox), (2oy+1,2ox+1), all channel c.
- Max compare is signed 32-bit; first tap loads the running max, the next three replace it if strictly greater. No ReLU, no saturation.
- States: IDLE, READ, WRITE, DONE.
  - IDLE: ready=1. start=1 → if H<2 or W<2 go to DONE (no memory access); else clear indices, out_count=0, go to READ with tap 0.
  - READ: mem_re=1, mem_addr = tap address. Hold address until mem_ready=1; on that cycle capture/compare mem_data_in, advance tap. After tap 3 accepted → WRITE.
  - WRITE: mem_we=1, mem_addr = output address, mem_data_out = max. Hold until mem_ready=1; then out_count+1, advance c/ox/oy. Last output accepted → DONE, else → READ tap 0.
  - DONE: done=1 for this single cycle, then IDLE.
- mem_re and mem_we never high together; at most one request outstanding.
- start while not IDLE is ignored; inputs (addresses, dims) must be held stable by the master for the whole job.
- Address/index arithmetic in 32 bits; no wrap handling beyond 32-bit modulo.

## Timing
- Reset values: done=0, ready=1, mem_re=0, mem_we=0, mem_addr=0, mem_data_out=0, out_count=0, state IDLE.
- rst=1 mid-job aborts immediately: next cycle all outputs at reset values, no further memory requests, no done pulse.
- All outputs registered. mem_re/mem_we/mem_addr/mem_data_out are valid from the first cycle of READ/WRITE and drop the cycle after the accepting mem_ready.
- With mem_ready tied 1: start sampled in cycle 0; first read in cycle 1; each output takes 5 cycles (4 reads, 1 write); done high in cycle 5·OH·OW·C + 1; ready high the following cycle.
- Degenerate job (H<2 or W<2): done high in cycle 1, out_count=0.
- Each cycle with mem_ready=0 stalls exactly one cycle, no state change.
- start asserted in the same cycle done is high is ignored (not IDLE).

## Test plan
- C=1, H=W=2, words {5,-3,9,7}, mem_ready=1 → one write of 9 to output_addr, done in cycle 6, out_count=1.
- C=2, H=W=4, ramp data, all-negative window {-8,-2,-5,-9} on c=1 → 8 writes in oy/ox/c order, that entry =-2, out_count=8, done in cycle 41.
- H=5, W=3, C=1 → OH=2, OW=1; only rows 0-3, columns 0-1 read; 2 writes.
- Random mem_ready (50%) on the 4×4×2 job → identical memory contents to the no-stall run; addresses held stable while mem_ready=0; never re and we together.
- H=1, W=8 → no mem_re/mem_we, done in cycle 1, out_count=0.
- rst asserted during the third READ of a job → next cycle mem_re=0, ready=1, no done; a fresh start then completes normally.
